// File: rtl/vga_timing_gen_if.sv
// Pixel-side and pin-side signal bundle of the VGA raster generator.
// The master side is the timing generator; the slave side is the pixel source / pins.
interface vga_timing_gen_if #(
    parameter int unsigned XWidth = 11,
    parameter int unsigned YWidth = 10
);
    logic              pixel_r;
    logic              pixel_g;
    logic              pixel_b;
    logic              step;
    logic [XWidth-1:0] x;
    logic [YWidth-1:0] y;
    logic              active;
    logic              line_end;
    logic              frame_end;
    logic              vga_r;
    logic              vga_g;
    logic              vga_b;
    logic              vga_hsync;
    logic              vga_vsync;

    modport master (
        input  pixel_r, pixel_g, pixel_b,
        output step, x, y, active, line_end, frame_end,
        output vga_r, vga_g, vga_b, vga_hsync, vga_vsync
    );

    modport slave (
        output pixel_r, pixel_g, pixel_b,
        input  step, x, y, active, line_end, frame_end,
        input  vga_r, vga_g, vga_b, vga_hsync, vga_vsync
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: prescaled pixel strobe, h/v counters,
// window decode and a one-pixel registered output stage keeping sync and colour aligned.
module vga_timing_gen #(
    parameter int unsigned HActive  = 640,
    parameter int unsigned HFront   = 16,
    parameter int unsigned HSync    = 96,
    parameter int unsigned HBack    = 48,
    parameter int unsigned VActive  = 480,
    parameter int unsigned VFront   = 10,
    parameter int unsigned VSync    = 2,
    parameter int unsigned VBack    = 33,
    parameter bit          HSyncPol = 1'b0,
    parameter bit          VSyncPol = 1'b0,
    parameter int unsigned PixelDiv = 2,
    parameter int unsigned XWidth   = 11,
    parameter int unsigned YWidth   = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    vga_timing_gen_if.master   vga
);
    localparam int unsigned HTotal = HActive + HFront + HSync + HBack;
    localparam int unsigned VTotal = VActive + VFront + VSync + VBack;
    localparam int unsigned PW     = (PixelDiv > 1) ? $clog2(PixelDiv) : 1;

    logic [PW-1:0]     presc_q, presc_d;
    logic [XWidth-1:0] hcount_q, hcount_d;
    logic [YWidth-1:0] vcount_q, vcount_d;
    logic              vga_r_q, vga_r_d;
    logic              vga_g_q, vga_g_d;
    logic              vga_b_q, vga_b_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;

    logic step;
    logic active;
    logic hs_raw;
    logic vs_raw;
    logic h_last;
    logic v_last;

    always_comb begin
        step   = enable && (presc_q == PW'(PixelDiv - 1));
        h_last = (hcount_q == XWidth'(HTotal - 1));
        v_last = (vcount_q == YWidth'(VTotal - 1));
        active = (hcount_q < XWidth'(HActive)) && (vcount_q < YWidth'(VActive));
        hs_raw = (hcount_q >= XWidth'(HActive + HFront)) &&
                 (hcount_q <  XWidth'(HActive + HFront + HSync));
        vs_raw = (vcount_q >= YWidth'(VActive + VFront)) &&
                 (vcount_q <  YWidth'(VActive + VFront + VSync));

        presc_d  = presc_q;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        vga_r_d  = vga_r_q;
        vga_g_d  = vga_g_q;
        vga_b_d  = vga_b_q;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;

        if (enable) begin
            presc_d = step ? '0 : presc_q + PW'(1);
        end

        // Everything downstream of the prescaler moves only on the pixel strobe,
        // so a frozen enable holds sync mid-pulse and resumes in place.
        if (step) begin
            if (h_last) begin
                hcount_d = '0;
                vcount_d = v_last ? '0 : vcount_q + YWidth'(1);
            end else begin
                hcount_d = hcount_q + XWidth'(1);
            end
            vga_r_d = active & vga.pixel_r;
            vga_g_d = active & vga.pixel_g;
            vga_b_d = active & vga.pixel_b;
            hsync_d = hs_raw ? HSyncPol : ~HSyncPol;
            vsync_d = vs_raw ? VSyncPol : ~VSyncPol;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q  <= '0;
            hcount_q <= '0;
            vcount_q <= '0;
            vga_r_q  <= 1'b0;
            vga_g_q  <= 1'b0;
            vga_b_q  <= 1'b0;
            hsync_q  <= ~HSyncPol;
            vsync_q  <= ~VSyncPol;
        end else begin
            presc_q  <= presc_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            vga_r_q  <= vga_r_d;
            vga_g_q  <= vga_g_d;
            vga_b_q  <= vga_b_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
        end
    end

    assign vga.step      = step;
    assign vga.x         = hcount_q;
    assign vga.y         = vcount_q;
    assign vga.active    = active;
    assign vga.line_end  = step && h_last;
    assign vga.frame_end = step && h_last && v_last;
    assign vga.vga_r     = vga_r_q;
    assign vga.vga_g     = vga_g_q;
    assign vga.vga_b     = vga_b_q;
    assign vga.vga_hsync = hsync_q;
    assign vga.vga_vsync = vsync_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations checked every cycle against a
// step-count raster model, plus hand-computed timing expectations.
module tb_vga_timing_gen;
    logic       clock;
    logic       reset;
    logic       enable;
    logic [2:0] pix [3];

    int checks;
    int errors;

    // 0: small, div 1, pol 0   1: small, div 3, pol 1   2: default, div 2, pol 0
    int HA [3] = '{8, 8, 640};
    int HF [3] = '{2, 2, 16};
    int HS [3] = '{3, 3, 96};
    int HB [3] = '{2, 2, 48};
    int VA [3] = '{4, 4, 480};
    int VF [3] = '{1, 1, 10};
    int VS [3] = '{2, 2, 2};
    int VB [3] = '{1, 1, 33};
    int DV [3] = '{1, 3, 2};
    int HP [3] = '{0, 1, 0};
    int VP [3] = '{0, 1, 0};

    vga_timing_gen_if #(.XWidth(4),  .YWidth(3))  if0 ();
    vga_timing_gen_if #(.XWidth(4),  .YWidth(3))  if1 ();
    vga_timing_gen_if #(.XWidth(11), .YWidth(10)) if2 ();

    vga_timing_gen #(
        .HActive(8), .HFront(2), .HSync(3), .HBack(2),
        .VActive(4), .VFront(1), .VSync(2), .VBack(1),
        .HSyncPol(1'b0), .VSyncPol(1'b0), .PixelDiv(1), .XWidth(4), .YWidth(3)
    ) u0 (.clock(clock), .reset(reset), .enable(enable), .vga(if0.master));

    vga_timing_gen #(
        .HActive(8), .HFront(2), .HSync(3), .HBack(2),
        .VActive(4), .VFront(1), .VSync(2), .VBack(1),
        .HSyncPol(1'b1), .VSyncPol(1'b1), .PixelDiv(3), .XWidth(4), .YWidth(3)
    ) u1 (.clock(clock), .reset(reset), .enable(enable), .vga(if1.master));

    vga_timing_gen #(.PixelDiv(2)) u2 (
        .clock(clock), .reset(reset), .enable(enable), .vga(if2.master));

    assign {if0.pixel_r, if0.pixel_g, if0.pixel_b} = pix[0];
    assign {if1.pixel_r, if1.pixel_g, if1.pixel_b} = pix[1];
    assign {if2.pixel_r, if2.pixel_g, if2.pixel_b} = pix[2];

    logic [10:0] ax [3];
    logic [9:0]  ay [3];
    logic        st [3], ac [3], le [3], fe [3], hs [3], vs [3];
    logic [2:0]  rgb [3];

    assign ax[0] = 11'(if0.x);  assign ay[0] = 10'(if0.y);
    assign ax[1] = 11'(if1.x);  assign ay[1] = 10'(if1.y);
    assign ax[2] = if2.x;       assign ay[2] = if2.y;
    assign st[0] = if0.step;  assign st[1] = if1.step;  assign st[2] = if2.step;
    assign ac[0] = if0.active; assign ac[1] = if1.active; assign ac[2] = if2.active;
    assign le[0] = if0.line_end; assign le[1] = if1.line_end; assign le[2] = if2.line_end;
    assign fe[0] = if0.frame_end; assign fe[1] = if1.frame_end; assign fe[2] = if2.frame_end;
    assign hs[0] = if0.vga_hsync; assign hs[1] = if1.vga_hsync; assign hs[2] = if2.vga_hsync;
    assign vs[0] = if0.vga_vsync; assign vs[1] = if1.vga_vsync; assign vs[2] = if2.vga_vsync;
    assign rgb[0] = {if0.vga_r, if0.vga_g, if0.vga_b};
    assign rgb[1] = {if1.vga_r, if1.vga_g, if1.vga_b};
    assign rgb[2] = {if2.vga_r, if2.vga_g, if2.vga_b};

    // Model state: pixels stepped since reset, prescaler phase, last latched colour.
    int         mn [3];
    int         mph [3];
    logic [2:0] mrgb [3];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int htot(int k);
        return HA[k] + HF[k] + HS[k] + HB[k];
    endfunction

    function automatic int vtot(int k);
        return VA[k] + VF[k] + VS[k] + VB[k];
    endfunction

    function automatic bit in_win(int c, int a, int f, int s);
        return (c >= a + f) && (c < a + f + s);
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            int h, v, p, ph, pv, e_hs, e_vs;
            bit e_st, e_le;
            h    = mn[k] % htot(k);
            v    = (mn[k] / htot(k)) % vtot(k);
            e_st = enable && (mph[k] == DV[k] - 1);
            e_le = e_st && (h == htot(k) - 1);
            if (mn[k] == 0) begin
                e_hs = 1 - HP[k];
                e_vs = 1 - VP[k];
            end else begin
                p    = mn[k] - 1;
                ph   = p % htot(k);
                pv   = (p / htot(k)) % vtot(k);
                e_hs = in_win(ph, HA[k], HF[k], HS[k]) ? HP[k] : 1 - HP[k];
                e_vs = in_win(pv, VA[k], VF[k], VS[k]) ? VP[k] : 1 - VP[k];
            end
            check($sformatf("x%0d", k), int'(ax[k]), h);
            check($sformatf("y%0d", k), int'(ay[k]), v);
            check($sformatf("step%0d", k), int'(st[k]), int'(e_st));
            check($sformatf("active%0d", k), int'(ac[k]), int'(h < HA[k] && v < VA[k]));
            check($sformatf("line_end%0d", k), int'(le[k]), int'(e_le));
            check($sformatf("frame_end%0d", k), int'(fe[k]), int'(e_le && v == vtot(k) - 1));
            check($sformatf("rgb%0d", k), int'(rgb[k]), int'(mrgb[k]));
            check($sformatf("hsync%0d", k), int'(hs[k]), e_hs);
            check($sformatf("vsync%0d", k), int'(vs[k]), e_vs);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                mn[k] = 0; mph[k] = 0; mrgb[k] = 3'b000;
            end else if (enable) begin
                if (mph[k] == DV[k] - 1) begin
                    int h, v;
                    h = mn[k] % htot(k);
                    v = (mn[k] / htot(k)) % vtot(k);
                    mrgb[k] = (h < HA[k] && v < VA[k]) ? pix[k] : 3'b000;
                    mn[k]++;
                    mph[k] = 0;
                end else begin
                    mph[k]++;
                end
            end
        end
        @(negedge clock);
        #1;
        compare_all();
    endtask

    initial begin
        int le0_first, le0_second, fe0_first, fe0_second, fe1_first, fe1_second;
        int hs0_first, hs0_lows, rgb0_high, vs0_lows, hs1_highs, cnt;
        bit found;

        checks = 0; errors = 0;
        for (int k = 0; k < 3; k++) begin
            mn[k] = 0; mph[k] = 0; mrgb[k] = 3'b000; pix[k] = 3'b000;
        end
        reset = 1'b1; enable = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 3; i++) tick();

        // Pinned reset values
        check("rst_x0", int'(ax[0]), 0);
        check("rst_y0", int'(ay[0]), 0);
        check("rst_vs0", int'(vs[0]), 1);
        check("rst_hs1_idle", int'(hs[1]), 0);
        check("rst_vs1_idle", int'(vs[1]), 0);
        check("rst_rgb0", int'(rgb[0]), 0);
        check("rst_active0", int'(ac[0]), 1);

        reset = 1'b0;
        le0_first = -1; le0_second = -1; fe0_first = -1; fe0_second = -1;
        fe1_first = -1; fe1_second = -1; hs0_first = -1;
        hs0_lows = 0; rgb0_high = 0; vs0_lows = 0; hs1_highs = 0;
        for (int c = 1; c <= 800; c++) begin
            pix[0] = 3'b111;
            pix[1] = 3'($urandom);
            pix[2] = 3'($urandom);
            tick();
            if (le[0]) begin
                if (le0_first < 0) le0_first = c;
                else if (le0_second < 0) le0_second = c;
            end
            if (fe[0]) begin
                if (fe0_first < 0) fe0_first = c;
                else if (fe0_second < 0) fe0_second = c;
            end
            if (fe[1]) begin
                if (fe1_first < 0) fe1_first = c;
                else if (fe1_second < 0) fe1_second = c;
            end
            if (c <= 15 && !hs[0]) begin
                hs0_lows++;
                if (hs0_first < 0) hs0_first = c;
            end
            if (c <= 15 && rgb[0] == 3'b111) rgb0_high++;
            if (c <= 120 && !vs[0]) vs0_lows++;
            if (c <= 45 && hs[1]) hs1_highs++;
        end
        check("line_end_period0", le0_second - le0_first, 15);
        check("frame_end_period0", fe0_second - fe0_first, 120);
        check("frame_end_period1", fe1_second - fe1_first, 360);
        check("hsync_start0", hs0_first, 11);
        check("hsync_width0", hs0_lows, 3);
        check("rgb_high_line0", rgb0_high, 8);
        check("vsync_width0", vs0_lows, 30);
        check("hsync_width1_pol1", hs1_highs, 9);

        // Freeze inside horizontal sync
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (ax[0] == 11'd12) found = 1;
            else begin
                pix[0] = 3'($urandom); pix[1] = 3'($urandom); pix[2] = 3'($urandom);
                tick();
            end
        end
        check("wait_x12", int'(found), 1);
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("freeze_x0", int'(ax[0]), 12);
            check("freeze_hs0", int'(hs[0]), 0);
        end
        enable = 1'b1;
        #1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (!hs[0]) cnt++;
            tick();
        end
        check("hsync_resume_width0", cnt, 2);

        // Reset mid-frame at (9,6)
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (ax[0] == 11'd9 && ay[0] == 10'd6) found = 1;
            else tick();
        end
        check("wait_9_6", int'(found), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("mid_rst_x0", int'(ax[0]), 0);
        check("mid_rst_y0", int'(ay[0]), 0);
        check("mid_rst_vs0", int'(vs[0]), 1);
        check("mid_rst_rgb0", int'(rgb[0]), 0);
        cnt = 0;
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (st[0]) cnt++;
            if (fe[0]) found = 1;
            else tick();
        end
        check("frame_end_after_rst0", cnt, 120);

        // Random enable and colour to exercise all models, including the default config
        for (int i = 0; i < 2000; i++) begin
            enable = ($urandom_range(9) != 0);
            pix[0] = 3'($urandom); pix[1] = 3'($urandom); pix[2] = 3'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
